// File: rtl/shuffle_pkg.sv
// Shared types and helpers for the stochastic bit-permutation network.
// Holds the mode encoding, Galois LFSR tap table and per-stage seed derivation.
package shuffle_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_RANDOM   = 2'b01,
    MODE_SWAP_ALL = 2'b10,
    MODE_RSVD     = 2'b11
  } shuffle_mode_t;

  localparam logic [31:0] STAGE_SEED_MUL = 32'h0000_9E37;
  localparam int          MAX_LFSR_W     = 32;

  // Right-shifting Galois masks; bit (t-1) set for every polynomial exponent t.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] t;
    case (width)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0001;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] width_mask(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
  endfunction

  // A zero state would lock the LFSR, so it is forced to 1.
  function automatic logic [31:0] stage_seed(input logic [31:0] s, input int unsigned k,
                                             input int unsigned width);
    logic [31:0] r;
    r = (s ^ (k * STAGE_SEED_MUL)) & width_mask(width);
    if (r == 32'h0) r = 32'h1;
    return r;
  endfunction

endpackage

// File: rtl/shuffle_stage.sv
// One odd-even transposition layer: swap network driven by a private LFSR, followed by
// the data/mode/valid register that forms one pipeline slot.
module shuffle_stage
  import shuffle_pkg::*;
#(
  parameter int          N      = 10,
  parameter int          LFSR_W = 16,
  parameter bit          ODD    = 1'b0,
  parameter int unsigned IDX    = 0,
  parameter logic [31:0] SEED   = 32'h0000_ACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [N-1:0]      in_data,
  input  shuffle_mode_t     in_mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output shuffle_mode_t     out_mode
);

  localparam int                FIRST    = ODD ? 1 : 0;
  localparam int                PAIRS    = (N - FIRST) / 2;
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] RST_SEED = LFSR_W'(stage_seed(SEED, IDX, LFSR_W));

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] reload_val;
  logic [N-1:0]      swapped;
  logic              take;

  assign take       = adv & in_valid;
  assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign reload_val = LFSR_W'(stage_seed(32'(seed), IDX, LFSR_W));

  // Pair j uses LFSR bit j; edge bits outside any pair fall through untouched.
  always_comb begin
    swapped = in_data;
    for (int j = 0; j < PAIRS; j++) begin
      if ((in_mode == MODE_SWAP_ALL) || ((in_mode == MODE_RANDOM) && lfsr[j])) begin
        swapped[FIRST + 2*j]     = in_data[FIRST + 2*j + 1];
        swapped[FIRST + 2*j + 1] = in_data[FIRST + 2*j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr      <= RST_SEED;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= MODE_BYPASS;
    end else begin
      if (seed_load) begin
        lfsr <= reload_val;
      end else if (take) begin
        lfsr <= lfsr_next;
      end
      if (adv) begin
        out_valid <= in_valid;
      end
      if (take) begin
        out_data <= swapped;
        out_mode <= in_mode;
      end
    end
  end

endmodule

// File: rtl/stochastic_shuffler.sv
// Pipelined random bit-permutation network: STAGES transposition layers with a
// valid/ready chain; a slot accepts new data when empty or when its successor moves.
module stochastic_shuffler
  import shuffle_pkg::*;
#(
  parameter int          N      = 10,
  parameter int          STAGES = 4,
  parameter int          LFSR_W = 16,
  parameter logic [31:0] SEED   = 32'h0000_ACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [N-1:0]      x_i,
  input  logic [1:0]        mode_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N-1:0]      x_o
);

  if (N < 1 || STAGES < 1) begin : g_bad_dims
    $error("stochastic_shuffler: N and STAGES must be at least 1");
  end
  if (LFSR_W < N/2) begin : g_bad_lfsr_narrow
    $error("stochastic_shuffler: LFSR_W must be at least N/2");
  end
  if (LFSR_W < 1 || LFSR_W > MAX_LFSR_W) begin : g_bad_lfsr_wide
    $error("stochastic_shuffler: LFSR_W must be between 1 and 32");
  end

  logic [STAGES:0]   vld;
  logic [N-1:0]      dat  [STAGES+1];
  shuffle_mode_t     mode [STAGES+1];
  logic [STAGES-1:0] adv;

  assign vld[0]  = valid_i;
  assign dat[0]  = x_i;
  assign mode[0] = shuffle_mode_t'(mode_i);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_last
      assign adv[k] = ~vld[k+1] | ready_i;
    end else begin : g_mid
      assign adv[k] = ~vld[k+1] | adv[k+1];
    end

    shuffle_stage #(
      .N      (N),
      .LFSR_W (LFSR_W),
      .ODD    ((k % 2) == 1),
      .IDX    (k),
      .SEED   (SEED)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .adv       (adv[k]),
      .in_valid  (vld[k]),
      .in_data   (dat[k]),
      .in_mode   (mode[k]),
      .seed_load (seed_load_i),
      .seed      (seed_i),
      .out_valid (vld[k+1]),
      .out_data  (dat[k+1]),
      .out_mode  (mode[k+1])
    );
  end

  assign ready_o = adv[0];
  assign valid_o = vld[STAGES];
  assign x_o     = dat[STAGES];

endmodule

// File: tb/tb_stochastic_shuffler.sv
// Scoreboard bench: drivers push expected vectors, monitors pop and compare on output transfers.
module tb_stochastic_shuffler;
  localparam int          N        = 10;
  localparam int          S        = 4;
  localparam int          LW       = 16;
  localparam logic [15:0] TAPS     = 16'hD008;
  localparam logic [15:0] RST_SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid_i = 1'b0, ready_i = 1'b1, seed_load_i = 1'b0;
  logic          ready_o, valid_o;
  logic [N-1:0]  x_i = '0, x_o;
  logic [1:0]    mode_i = 2'b00;
  logic [LW-1:0] seed_i = '0;

  logic          valid4_i = 1'b0, ready4_i = 1'b1, seed_load4_i = 1'b0;
  logic          ready4_o, valid4_o;
  logic [3:0]    x4_i = '0, x4_o;
  logic [1:0]    mode4_i = 2'b00;
  logic [LW-1:0] seed4_i = '0;

  stochastic_shuffler #(.N(N), .STAGES(S), .LFSR_W(LW), .SEED(32'h0000ACE1)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o), .x_i(x_i),
    .mode_i(mode_i), .seed_load_i(seed_load_i), .seed_i(seed_i), .valid_o(valid_o),
    .ready_i(ready_i), .x_o(x_o));

  stochastic_shuffler #(.N(4), .STAGES(4), .LFSR_W(LW), .SEED(32'h0000ACE1)) dut4 (
    .clk(clk), .reset_n(reset_n), .valid_i(valid4_i), .ready_o(ready4_o), .x_i(x4_i),
    .mode_i(mode4_i), .seed_load_i(seed_load4_i), .seed_i(seed4_i), .valid_o(valid4_o),
    .ready_i(ready4_i), .x_o(x4_o));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: each stage's LFSR steps once per vector, so state is tracked per vector.
  logic [15:0] ml [S];

  function automatic logic [15:0] bseed(input logic [15:0] s, input int k);
    logic [31:0] m;
    logic [15:0] r;
    m = 32'(k) * 32'h0000_9E37;
    r = s ^ m[15:0];
    return (r == 16'h0) ? 16'h1 : r;
  endfunction

  function automatic logic [15:0] step16(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
  endfunction

  task automatic model_seed(input logic [15:0] s);
    for (int k = 0; k < S; k++) ml[k] = bseed(s, k);
  endtask

  task automatic model_perm(input logic [N-1:0] x, input logic [1:0] md, output logic [N-1:0] y);
    logic t;
    y = x;
    for (int k = 0; k < S; k++) begin
      for (int j = 0; (k % 2) + 2*j + 1 < N; j++) begin
        if (md == 2'b10 || (md == 2'b01 && ml[k][j])) begin
          t = y[(k % 2) + 2*j];
          y[(k % 2) + 2*j] = y[(k % 2) + 2*j + 1];
          y[(k % 2) + 2*j + 1] = t;
        end
      end
      ml[k] = step16(ml[k]);
    end
  endtask

  typedef struct {
    logic [N-1:0] x_in;
    logic [N-1:0] x_exp;
    int           t_in;
    bit           chk_lat;
  } ent_t;
  typedef struct {
    logic [3:0] x_exp;
    int         t_in;
  } ent4_t;

  ent_t         sb [$];
  ent4_t        sb4 [$];
  logic [N-1:0] obs [$];
  int           n_out = 0;
  int           n_diff = 0;

  task automatic send(input logic [N-1:0] x, input logic [1:0] md, input bit lat,
                      input bit has_exp, input logic [N-1:0] expv);
    ent_t e;
    int   w;
    w = 0;
    valid_i = 1'b1; x_i = x; mode_i = md;
    @(negedge clk);
    while (!ready_o && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (ready_o) begin
      e.x_in = x;
      model_perm(x, md, e.x_exp);
      if (has_exp) e.x_exp = expv;
      e.t_in = cyc;
      e.chk_lat = lat;
      sb.push_back(e);
    end else begin
      fail_now("send_ready_timeout");
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send4(input logic [3:0] x, input logic [1:0] md, input logic [3:0] expv);
    ent4_t e;
    int    w;
    w = 0;
    valid4_i = 1'b1; x4_i = x; mode4_i = md;
    @(negedge clk);
    while (!ready4_o && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (ready4_o) begin
      e.x_exp = expv;
      e.t_in = cyc;
      sb4.push_back(e);
    end else begin
      fail_now("send4_ready_timeout");
    end
    @(posedge clk); #1;
    valid4_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0 || sb4.size() != 0) begin
      fail_now("drain_timeout");
      sb.delete();
      sb4.delete();
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor for the N=10 instance, plus hold-while-stalled rule on the output.
  logic         pv_o = 1'b0, pr_i = 1'b0, prst = 1'b0;
  logic [N-1:0] px_o = '0;
  always @(negedge clk) begin
    ent_t e;
    if (reset_n && prst && pv_o && !pr_i) begin
      chk("hold_valid_o", 32'(valid_o), 32'd1);
      chk("hold_x_o", 32'(x_o), 32'(px_o));
    end
    if (reset_n && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        fail_now($sformatf("unexpected_output x_o=%0h", x_o));
      end else begin
        e = sb.pop_front();
        chk("x_o", 32'(x_o), 32'(e.x_exp));
        chk("popcount", 32'($countones(x_o)), 32'($countones(e.x_in)));
        if (e.chk_lat) chk("latency", 32'(cyc - e.t_in), 32'(S));
        n_out++;
        if (x_o != e.x_in) n_diff++;
        obs.push_back(x_o);
      end
    end
    pv_o = valid_o; pr_i = ready_i; px_o = x_o; prst = reset_n;
  end

  always @(negedge clk) begin
    ent4_t e;
    if (reset_n && valid4_o && ready4_i) begin
      if (sb4.size() == 0) begin
        fail_now($sformatf("unexpected_output4 x_o=%0h", x4_o));
      end else begin
        e = sb4.pop_front();
        chk("x4_o", 32'(x4_o), 32'(e.x_exp));
        chk("latency4", 32'(cyc - e.t_in), 32'd4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] vec8 [8];
  logic [N-1:0] first8 [$];
  logic [N-1:0] hold_x;
  int           base_out, base_diff;

  initial begin
    vec8 = '{10'h155, 10'h2AA, 10'h00F, 10'h3C0, 10'h211, 10'h0F0, 10'h30C, 10'h1E1};
    model_seed(RST_SEED);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_x_o", 32'(x_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_valid4_o", 32'(valid4_o), 32'd0);
    chk("rst_x4_o", 32'(x4_o), 32'd0);
    @(posedge clk); #1;

    // Narrow instance: first RANDOM vector exercises the reset seeds, then full reversals.
    send4(4'b0100, 2'b01, 4'b1000);
    send4(4'b0001, 2'b10, 4'b1000);
    send4(4'b0011, 2'b10, 4'b1100);
    send4(4'b0110, 2'b11, 4'b0110);
    drain();

    // Wide instance directed vectors.
    send(10'b10_0000_0001, 2'b00, 1'b1, 1'b1, 10'b10_0000_0001);
    drain();
    send(10'b00_0000_0001, 2'b10, 1'b1, 1'b1, 10'b00_0001_0000);
    send(10'b10_0000_0000, 2'b10, 1'b1, 1'b1, 10'b00_0010_0000);
    send(10'b01_1010_0110, 2'b11, 1'b1, 1'b1, 10'b01_1010_0110);
    drain();

    // Back-to-back RANDOM traffic.
    base_out = n_out; base_diff = n_diff;
    for (int i = 0; i < 1000; i++) send(N'($urandom), 2'b01, 1'b1, 1'b0, '0);
    drain();
    chk("random_count", 32'(n_out - base_out), 32'd1000);
    chk("random_permuted", 32'((n_diff - base_diff) > 0), 32'd1);

    // Seed reload replays the same permutation sequence.
    for (int r = 0; r < 2; r++) begin
      seed_load_i = 1'b1; seed_i = 16'h1234;
      @(posedge clk); #1;
      seed_load_i = 1'b0;
      model_seed(16'h1234);
      obs.delete();
      for (int i = 0; i < 8; i++) send(vec8[i], 2'b01, 1'b1, 1'b0, '0);
      drain();
      if (r == 0) begin
        first8 = obs;
      end else begin
        chk("replay_count", 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs.size() && i < first8.size(); i++)
          chk("replay_match", 32'(obs[i]), 32'(first8[i]));
      end
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_seed(RST_SEED);
    for (int i = 0; i < 8; i++) send(vec8[i], 2'b01, 1'b1, 1'b0, '0);
    drain();

    // Backpressure: stall output, check hold, fill every slot, then release.
    ready_i = 1'b0;
    base_out = n_out;
    send(10'h0A5, 2'b01, 1'b0, 1'b0, '0);
    send(10'h35A, 2'b01, 1'b0, 1'b0, '0);
    send(10'h1C3, 2'b01, 1'b0, 1'b0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    hold_x = x_o;
    chk("stall_ready_o_open", 32'(ready_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid_o", 32'(valid_o), 32'd1);
      chk("stall_x_o", 32'(x_o), 32'(hold_x));
    end
    @(posedge clk); #1;
    send(10'h2F0, 2'b01, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("stall_ready_o_full", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    ready_i = 1'b1;
    drain();
    chk("stall_count", 32'(n_out - base_out), 32'd4);

    // Reset with two vectors in flight.
    send(10'h3F0, 2'b01, 1'b1, 1'b0, '0);
    send(10'h00F, 2'b10, 1'b1, 1'b0, '0);
    reset_n = 1'b0;
    sb.delete();
    model_seed(RST_SEED);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("flush_valid_o", 32'(valid_o), 32'd0);
    chk("flush_x_o", 32'(x_o), 32'd0);
    chk("flush_ready_o", 32'(ready_o), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    send(10'h2B7, 2'b01, 1'b1, 1'b0, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
